// File: rtl/spmdv_result_collector.sv
// spmdv_result_collector: requantizes SpMDV row results into an 8-bit output FIFO
// and tracks the per-token argmax over 16 tokens of 256 rows each.
`timescale 1ns/1ps
`default_nettype none

module spmdv_result_collector #(
  parameter int SHIFT = 8,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] i_result,
  input  logic        i_valid,
  input  logic        o_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        argmax_valid,
  output logic [7:0]  argmax_idx,
  output logic [21:0] argmax_val,
  output logic [3:0]  token_idx,
  output logic        all_done,
  output logic        overflow
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [22:0] RND      = 23'(1) << (SHIFT - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t        state_q, state_d;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    row_cnt_q;
  logic [21:0]   run_max_q;
  logic [7:0]    run_idx_q;
  logic          argmax_valid_q;
  logic [7:0]    argmax_idx_q;
  logic [21:0]   argmax_val_q;
  logic [3:0]    token_idx_q;
  logic          overflow_q;

  logic [22:0]   sum;
  logic [22:0]   shifted;
  logic [7:0]    q_val;
  logic          accept, pop, push, drop, full, last_row, take_new;

  // Requantize with round-half-up, then clamp to the 8-bit range.
  assign sum     = {1'b0, i_result} + RND;
  assign shifted = sum >> SHIFT;
  assign q_val   = (shifted > 23'd255) ? 8'hFF : shifted[7:0];

  assign accept   = i_valid && (state_q == COLLECT);
  assign full     = (count_q == FULL_CNT);
  assign pop      = o_valid && o_ready;
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;
  assign last_row = (row_cnt_q == 8'hFF);
  assign take_new = (row_cnt_q == 8'd0) || (i_result > run_max_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (accept && last_row && token_idx_q == 4'd15) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= COLLECT;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      row_cnt_q      <= '0;
      run_max_q      <= '0;
      run_idx_q      <= '0;
      argmax_valid_q <= 1'b0;
      argmax_idx_q   <= '0;
      argmax_val_q   <= '0;
      token_idx_q    <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      argmax_valid_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
      if (accept) begin
        row_cnt_q <= row_cnt_q + 8'd1;
        if (take_new) begin
          run_max_q <= i_result;
          run_idx_q <= row_cnt_q;
        end
        // The final row may itself be the maximum, so fold it in directly.
        if (last_row) begin
          argmax_valid_q <= 1'b1;
          argmax_val_q   <= take_new ? i_result  : run_max_q;
          argmax_idx_q   <= take_new ? row_cnt_q : run_idx_q;
          if (token_idx_q != 4'd15) token_idx_q <= token_idx_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {q_val, last_row};
  end

  assign o_valid      = (count_q != '0);
  assign o_data       = o_valid ? mem_q[rd_ptr_q][8:1] : 8'd0;
  assign o_last       = o_valid & mem_q[rd_ptr_q][0];
  assign argmax_valid = argmax_valid_q;
  assign argmax_idx   = argmax_idx_q;
  assign argmax_val   = argmax_val_q;
  assign token_idx    = token_idx_q;
  assign all_done     = (state_q == DONE);
  assign overflow     = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_spmdv_result_collector.sv
// Self-checking bench for spmdv_result_collector: queue-based reference model
// compared every cycle, plus directed vectors with hand-computed expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_spmdv_result_collector;

  localparam int SHIFT = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [21:0] i_result = '0;
  logic        i_valid = 1'b0;
  logic        o_ready = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        argmax_valid;
  logic [7:0]  argmax_idx;
  logic [21:0] argmax_val;
  logic [3:0]  token_idx;
  logic        all_done;
  logic        overflow;

  spmdv_result_collector #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_result     (i_result),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .argmax_valid (argmax_valid),
    .argmax_idx   (argmax_idx),
    .argmax_val   (argmax_val),
    .token_idx    (token_idx),
    .all_done     (all_done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] mq[$];
  int         m_row, m_tok, m_aidx;
  longint     m_aval;
  bit         m_done, m_ovf, m_pulse;
  int         vals[256];
  int         dut_pulses;

  function automatic int requant(input int x);
    int r;
    r = (x + (1 << (SHIFT - 1))) >> SHIFT;
    return (r > 255) ? 255 : r;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit pop, acc;
    int sz;
    if (!rst) begin
      mq.delete();
      m_row = 0; m_tok = 0; m_aidx = 0; m_aval = 0;
      m_done = 0; m_ovf = 0; m_pulse = 0;
    end else begin
      sz      = mq.size();
      pop     = (sz != 0) && o_ready;
      acc     = i_valid && !m_done;
      m_pulse = 0;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        if (sz < DEPTH || pop) mq.push_back({8'(requant(int'(i_result))), m_row == 255});
        else m_ovf = 1;
        vals[m_row] = int'(i_result);
        if (m_row == 255) begin
          m_aidx = 0;
          m_aval = vals[0];
          for (int i = 1; i < 256; i++)
            if (vals[i] > m_aval) begin m_aval = vals[i]; m_aidx = i; end
          m_pulse = 1;
          if (m_tok == 15) m_done = 1; else m_tok++;
        end
        m_row = (m_row + 1) % 256;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    bit ev;
    #2;
    ev = (mq.size() != 0);
    chk("o_valid", o_valid, ev);
    if (ev) begin
      chk("o_data", o_data, mq[0][8:1]);
      chk("o_last", o_last, mq[0][0]);
    end else if (!rst) begin
      chk("o_last_rst", o_last, 0);
    end
    chk("argmax_valid", argmax_valid, m_pulse);
    chk("argmax_idx",   argmax_idx,   m_aidx);
    chk("argmax_val",   argmax_val,   m_aval);
    chk("token_idx",    token_idx,    m_tok);
    chk("all_done",     all_done,     m_done);
    chk("overflow",     overflow,     m_ovf);
    if (!rst) dut_pulses = 0;
    else if (argmax_valid) dut_pulses++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int x, input bit rdy);
    @(negedge clk);
    i_valid  = v;
    i_result = 22'(x);
    o_ready  = rdy;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    @(negedge clk);
    chk("rst_o_valid",      o_valid,      0);
    chk("rst_o_last",       o_last,       0);
    chk("rst_argmax_valid", argmax_valid, 0);
    chk("rst_argmax_idx",   argmax_idx,   0);
    chk("rst_argmax_val",   argmax_val,   0);
    chk("rst_token_idx",    token_idx,    0);
    chk("rst_all_done",     all_done,     0);
    chk("rst_overflow",     overflow,     0);
    repeat (cycles - 1) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain(output int got[$]);
    got.delete();
    o_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (o_valid) got.push_back(int'(o_data));
      @(negedge clk);
    end
  endtask

  initial begin
    int vin[4];
    int vexp[4];
    int got[$];
    vin  = '{127, 128, 384, 22'h3FFFFF};
    vexp = '{0, 1, 2, 255};

    do_reset(3);

    // Rounding vectors, one output per input one cycle later.
    for (int k = 0; k < 4; k++) begin
      drive(1, vin[k], 1);
      drive(0, 0, 1);
      chk("rnd_valid", o_valid, 1);
      chk("rnd_data",  o_data,  vexp[k]);
    end

    // Token 0 with the maximum tied at rows 7 and 9.
    do_reset(2);
    for (int r = 0; r < 256; r++) drive(1, (r == 7 || r == 9) ? 1000 : r, 1);
    drive(0, 0, 1);
    chk("tok0_pulse", argmax_valid, 1);
    chk("tok0_idx",   argmax_idx,   7);
    chk("tok0_val",   argmax_val,   1000);
    chk("tok0_token", token_idx,    1);
    chk("tok0_last",  o_last,       1);
    chk("tok0_data",  o_data,       1);
    drive(0, 0, 1);
    chk("tok0_pulse_end", argmax_valid, 0);
    chk("tok0_idx_hold",  argmax_idx,   7);

    // Backpressure: 20 inputs into a 16-entry FIFO, then drain.
    do_reset(2);
    for (int k = 1; k <= 20; k++) begin
      drive(1, k * 256, 0);
      if (k == 2)  chk("bp_valid",    o_valid,  1);
      if (k == 17) chk("bp_ovf_16",   overflow, 0);
      if (k == 18) chk("bp_ovf_17",   overflow, 1);
    end
    drive(0, 0, 0);
    drain(got);
    chk("bp_drain_count", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) chk("bp_drain_data", got[i], i + 1);

    // Full FIFO with push and pop in the same cycle.
    do_reset(2);
    for (int k = 1; k <= 17; k++) drive(1, k * 256, k == 17);
    drive(0, 0, 0);
    chk("fullpp_ovf", overflow, 0);
    drive(1, 18 * 256, 0);
    drive(0, 0, 0);
    chk("fullpp_still_full", overflow, 1);
    drain(got);
    chk("fullpp_drain_count", got.size(), 16);
    if (got.size() > 0) chk("fullpp_first", got[0], 2);
    if (got.size() > 15) chk("fullpp_last", got[15], 17);

    // Full run of 16 tokens, then inputs that must be ignored.
    do_reset(2);
    for (int t = 0; t < 16; t++)
      for (int r = 0; r < 256; r++)
        drive(1, ((r * 37) % 200 + t) * 1000, 1);
    for (int k = 0; k < 5; k++) drive(1, 1000 * (k + 1), 1);
    drive(0, 0, 1);
    repeat (3) @(negedge clk);
    chk("done_all_done", all_done,   1);
    chk("done_token",    token_idx,  15);
    chk("done_pulses",   dut_pulses, 16);
    chk("done_no_out",   o_valid,    0);
    chk("done_ovf",      overflow,   0);

    // Reset mid-token with data still queued.
    do_reset(2);
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < 256; r++) drive(1, r * 3 + t, 1);
    for (int r = 0; r < 100; r++) drive(1, r + 5, r < 95);
    do_reset(2);
    for (int r = 0; r < 256; r++) drive(1, r, 1);
    drive(0, 0, 1);
    chk("rr_pulse", argmax_valid, 1);
    chk("rr_idx",   argmax_idx,   255);
    chk("rr_val",   argmax_val,   255);
    chk("rr_token", token_idx,    1);
    chk("rr_last",  o_last,       1);

    repeat (4) drive(0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
